dmem_sram_bridge: RTL

Responder for the datapath's data-memory port. Accepts one read (`mread`) or write (`mwrite`) request at a time from the memory stage and drives a class-SRAM bus (req/addr_ok/data_ok). It returns the raw read word on `rd` and stalls the pipeline through the hazard unit until the transaction completes. Sits between `datapath` and the top-level data bus. A flush from the exception logic cancels a transaction, or discards its response.

---
 rtl/dmem_sram_bridge_pkg.sv | 40 ++++
 rtl/dmem_sram_bridge.sv | 124 ++++++++++++
 2 files changed

// File: rtl/dmem_sram_bridge_pkg.sv
// Shared memory-stage types: request structs, bus FSM state codes, kseg mapping.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package dmem_sram_bridge_pkg;

  typedef logic [31:0] word_t;

  // Read request from the memory stage: {ren, addr, size}
  typedef struct packed {
    logic       ren;
    word_t      addr;
    logic [1:0] size;
  } m_r_t;

  // Write request from the memory stage: {wen, addr, size, data}
  typedef struct packed {
    logic       wen;
    word_t      addr;
    logic [1:0] size;
    word_t      data;
  } m_w_t;

  // Bus-side transaction state; plain codes so legacy logic can compare directly.
  typedef logic [2:0] dbus_state_t;
  localparam dbus_state_t ST_IDLE  = 3'd0;
  localparam dbus_state_t ST_REQ   = 3'd1;
  localparam dbus_state_t ST_RESP  = 3'd2;
  localparam dbus_state_t ST_DRAIN = 3'd3;
  localparam dbus_state_t ST_DONE  = 3'd4;

  // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) fold onto the low 512 MB physical window.
  // Shared with the instruction-side bridge.
  function automatic word_t paddr_map(input word_t vaddr, input logic map_kseg);
    if (map_kseg && (vaddr[31:30] == 2'b10)) begin
      return vaddr & 32'h1FFF_FFFF;
    end
    return vaddr;
  endfunction

endpackage

// File: rtl/dmem_sram_bridge.sv
// Data-memory responder: turns one mread/mwrite request into a class-SRAM bus transaction.
// Latency: 3 cycles best case from request to release (IDLE latch, REQ+addr_ok, RESP+data_ok, DONE).
// Backpressure: holds stall high until the transaction completes; flush withdraws or drains it.
//
// Ports:
//   clk, reset        - core clock, async active-low reset
//   mread, mwrite     - memory-stage requests (write wins when both are set)
//   flush             - exception/ERET flush of the memory stage
//   rd                - last completed read word
//   stall             - freezes the pipeline front-end while a transaction is in flight
//   data_*            - class-SRAM bus (req/addr_ok/data_ok handshake)
module dmem_sram_bridge
  import dmem_sram_bridge_pkg::*;
#(
  parameter bit MAP_KSEG = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  m_r_t        mread,
  input  m_w_t        mwrite,
  input  logic        flush,
  output word_t       rd,
  output logic        stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output word_t       data_addr,
  output word_t       data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  word_t       data_rdata
);

  dbus_state_t state;
  logic        valid;
  logic        accept;
  word_t       sel_addr;
  logic [1:0]  sel_size;
  word_t       sel_wdata;

  // Write takes priority; the read half of a simultaneous request is dropped.
  always_comb begin
    valid     = mread.ren | mwrite.wen;
    accept    = (state == ST_IDLE) & valid & ~flush;
    sel_addr  = mwrite.wen ? mwrite.addr : mread.addr;
    sel_size  = mwrite.wen ? mwrite.size : mread.size;
    sel_wdata = mwrite.wen ? mwrite.data : 32'h0;
  end

  // The IDLE term lets the stage freeze in the very cycle the request appears.
  assign stall = accept | (state == ST_REQ) | (state == ST_RESP) | (state == ST_DRAIN);

  // data_wr/size/addr/wdata double as the request registers, so the bus sees
  // flop outputs that stay stable for the whole of REQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      rd         <= 32'h0;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= 32'h0;
      data_wdata <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_REQ;
            data_req   <= 1'b1;
            data_wr    <= mwrite.wen;
            data_size  <= sel_size;
            data_addr  <= paddr_map(sel_addr, MAP_KSEG);
            data_wdata <= sel_wdata;
          end
        end

        ST_REQ: begin
          // data_ok cannot legally coincide with addr_ok; it is ignored here.
          if (data_addr_ok) begin
            data_req <= 1'b0;
            state    <= flush ? ST_DRAIN : ST_RESP;
          end else if (flush) begin
            data_req <= 1'b0;
            state    <= ST_IDLE;
          end
        end

        ST_RESP: begin
          if (data_data_ok) begin
            // A flush landing with the response means the consumer is gone:
            // skip DONE and keep the old rd.
            if (flush) begin
              state <= ST_IDLE;
            end else begin
              if (!data_wr) begin
                rd <= data_rdata;
              end
              state <= ST_DONE;
            end
          end else if (flush) begin
            state <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (data_data_ok) begin
            state <= ST_IDLE;
          end
        end

        ST_DONE: begin
          // The completed request is still on mread/mwrite this cycle; do not re-accept it.
          state <= ST_IDLE;
        end

        default: begin
          state    <= ST_IDLE;
          data_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
